// File: rtl/rd_serial_tx_if.sv
// rd_serial_tx_if: trace buffer read port between rd_serial_tx and block RAM.
// RD_DATA is valid one cycle after RD_EN.
interface rd_serial_tx_if #(
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0] RD_ADDR;
  logic                  RD_EN;
  logic [31:0]           RD_DATA;

  modport master (
    output RD_ADDR,
    output RD_EN,
    input  RD_DATA
  );

  modport slave (
    input  RD_ADDR,
    input  RD_EN,
    output RD_DATA
  );
endinterface

// File: rtl/rd_serial_tx.sv
// rd_serial_tx: two-lane serial transmitter streaming one trace buffer per trigger.
// Define RD_SERIAL_TX_CHECKSUM_EN to append an XOR checksum word to each transfer.
module rd_serial_tx #(
  parameter int WORDS_PER_BUF = 2048,
  parameter int ADDR_WIDTH    = 13,
  parameter int HALF_PERIOD   = 1
) (
  input  logic       CLK_IN,
  input  logic       RESETN_IN,
  input  logic       TRIG_IN,
  input  logic [1:0] BUF_NUM,
  rd_serial_tx_if.master mem,
  output logic       SERIAL_CLK_OUT,
  output logic       SERIAL_DATA0_OUT,
  output logic       SERIAL_DATA1_OUT,
  output logic       ENABLE_XFR_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVERRUN,
  input  logic       CLR_OVERRUN
);

  localparam int IW  = $clog2(WORDS_PER_BUF);
  localparam int CW  = $clog2(HALF_PERIOD + 1);
`ifdef RD_SERIAL_TX_CHECKSUM_EN
  localparam int NW  = WORDS_PER_BUF + 1;
`else
  localparam int NW  = WORDS_PER_BUF;
`endif
  localparam int WCW = $clog2(NW + 1);

  localparam logic [CW-1:0]  HMAX   = CW'(HALF_PERIOD - 1);
  localparam logic [WCW-1:0] LAST_W = WCW'(NW - 1);
  localparam logic [WCW-1:0] LAST_D = WCW'(WORDS_PER_BUF - 1);
  localparam logic [WCW-1:0] PRE_W  = WCW'(WORDS_PER_BUF - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_FIN
  } state_t;

  state_t          state;
  logic            trig_q;
  logic [1:0]      buf_q;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   hcnt;
  logic [3:0]      bitc;
  logic [WCW-1:0]  wcnt;
  logic [15:0]     sh0;
  logic [15:0]     sh1;
  logic [31:0]     hold;
  logic            rd_v;
  logic [31:0]     nxt;
  logic            trig_rise;
`ifdef RD_SERIAL_TX_CHECKSUM_EN
  logic [31:0]     acc;
`endif

  assign trig_rise        = TRIG_IN & ~trig_q;
  assign SERIAL_DATA0_OUT = sh0[15];
  assign SERIAL_DATA1_OUT = sh1[15];

  always_comb begin
    nxt = hold;
`ifdef RD_SERIAL_TX_CHECKSUM_EN
    if (wcnt == LAST_D) nxt = acc;
`endif
  end

  always_ff @(posedge CLK_IN or negedge RESETN_IN) begin
    if (!RESETN_IN) begin
      state          <= S_IDLE;
      trig_q         <= 1'b0;
      buf_q          <= '0;
      idx            <= '0;
      hcnt           <= '0;
      bitc           <= '0;
      wcnt           <= '0;
      sh0            <= '0;
      sh1            <= '0;
      hold           <= '0;
      rd_v           <= 1'b0;
      mem.RD_EN      <= 1'b0;
      mem.RD_ADDR    <= '0;
      SERIAL_CLK_OUT <= 1'b0;
      ENABLE_XFR_OUT <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      OVERRUN        <= 1'b0;
`ifdef RD_SERIAL_TX_CHECKSUM_EN
      acc            <= '0;
`endif
    end else begin
      trig_q    <= TRIG_IN;
      mem.RD_EN <= 1'b0;
      DONE      <= 1'b0;
      rd_v      <= mem.RD_EN;
      if (rd_v && state == S_SHIFT) hold <= mem.RD_DATA;
      if (trig_rise && BUSY) OVERRUN <= 1'b1;
      else if (CLR_OVERRUN)  OVERRUN <= 1'b0;
      unique case (state)
        S_IDLE: if (trig_rise) begin
          buf_q       <= BUF_NUM;
          idx         <= '0;
          mem.RD_ADDR <= ADDR_WIDTH'({BUF_NUM, {IW{1'b0}}});
          mem.RD_EN   <= 1'b1;
          BUSY        <= 1'b1;
          state       <= S_FETCH;
`ifdef RD_SERIAL_TX_CHECKSUM_EN
          acc         <= '0;
`endif
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          sh0            <= mem.RD_DATA[31:16];
          sh1            <= mem.RD_DATA[15:0];
          ENABLE_XFR_OUT <= 1'b1;
          SERIAL_CLK_OUT <= 1'b0;
          hcnt           <= '0;
          bitc           <= '0;
          wcnt           <= '0;
          idx            <= idx + IW'(1);
          mem.RD_ADDR    <= ADDR_WIDTH'({buf_q, idx + IW'(1)});
          mem.RD_EN      <= 1'b1;
          state          <= S_SHIFT;
`ifdef RD_SERIAL_TX_CHECKSUM_EN
          acc            <= acc ^ mem.RD_DATA;
`endif
        end
        S_SHIFT: if (hcnt == HMAX) begin
          hcnt           <= '0;
          SERIAL_CLK_OUT <= ~SERIAL_CLK_OUT;
          // falling edge: launch the next bit, or the next word after bit 0
          if (SERIAL_CLK_OUT) begin
            if (bitc == 4'd15 && wcnt == LAST_W) begin
              ENABLE_XFR_OUT <= 1'b0;
              sh0            <= '0;
              sh1            <= '0;
              DONE           <= 1'b1;
              state          <= S_FIN;
            end else if (bitc == 4'd15) begin
              sh0  <= nxt[31:16];
              sh1  <= nxt[15:0];
              bitc <= '0;
              wcnt <= wcnt + WCW'(1);
`ifdef RD_SERIAL_TX_CHECKSUM_EN
              if (wcnt < LAST_D) acc <= acc ^ nxt;
`endif
              if (wcnt < PRE_W) begin
                idx         <= idx + IW'(1);
                mem.RD_ADDR <= ADDR_WIDTH'({buf_q, idx + IW'(1)});
                mem.RD_EN   <= 1'b1;
              end
            end else begin
              sh0  <= {sh0[14:0], 1'b0};
              sh1  <= {sh1[14:0], 1'b0};
              bitc <= bitc + 4'd1;
            end
          end
        end else begin
          hcnt <= hcnt + CW'(1);
        end
        S_FIN: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_serial_tx.sv
// tb_rd_serial_tx: two transmitters (half period 1 and 3) against a word-level
// reference built from the buffer contents; lanes are reassembled at the receiver.
module tb_rd_serial_tx;

  localparam int W   = 4;
  localparam int AW  = 4;
  localparam int HP0 = 1;
  localparam int HP1 = 3;
`ifdef RD_SERIAL_TX_CHECKSUM_EN
  localparam int NW  = W + 1;
`else
  localparam int NW  = W;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] trig = '0;
  logic [1:0] clr = '0;
  logic [1:0] bn [2];
  wire  [1:0] sclk, d0, d1, en, busy, done, ovr;
  logic [31:0] mem [16];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rd_serial_tx_if #(.ADDR_WIDTH(AW)) mif0 ();
  rd_serial_tx_if #(.ADDR_WIDTH(AW)) mif1 ();

  rd_serial_tx #(.WORDS_PER_BUF(W), .ADDR_WIDTH(AW), .HALF_PERIOD(HP0)) u0 (
    .CLK_IN(clk), .RESETN_IN(rst_n), .TRIG_IN(trig[0]), .BUF_NUM(bn[0]),
    .mem(mif0.master), .SERIAL_CLK_OUT(sclk[0]), .SERIAL_DATA0_OUT(d0[0]),
    .SERIAL_DATA1_OUT(d1[0]), .ENABLE_XFR_OUT(en[0]), .BUSY(busy[0]),
    .DONE(done[0]), .OVERRUN(ovr[0]), .CLR_OVERRUN(clr[0])
  );

  rd_serial_tx #(.WORDS_PER_BUF(W), .ADDR_WIDTH(AW), .HALF_PERIOD(HP1)) u1 (
    .CLK_IN(clk), .RESETN_IN(rst_n), .TRIG_IN(trig[1]), .BUF_NUM(bn[1]),
    .mem(mif1.master), .SERIAL_CLK_OUT(sclk[1]), .SERIAL_DATA0_OUT(d0[1]),
    .SERIAL_DATA1_OUT(d1[1]), .ENABLE_XFR_OUT(en[1]), .BUSY(busy[1]),
    .DONE(done[1]), .OVERRUN(ovr[1]), .CLR_OVERRUN(clr[1])
  );

  always @(posedge clk) if (mif0.RD_EN) mif0.RD_DATA <= mem[mif0.RD_ADDR];
  always @(posedge clk) if (mif1.RD_EN) mif1.RD_DATA <= mem[mif1.RD_ADDR];

  // receiver side: sample lanes on serial clock rise, reassemble words
  int          en_cnt [2];
  int          nb [2];
  int          nw [2];
  int          bad [2];
  int          dcnt [2];
  int          dend [2];
  logic [15:0] s0 [2];
  logic [15:0] s1 [2];
  logic [31:0] got [2][8];
  logic [1:0]  p_sclk = '0, p_en = '0, p_d0 = '0, p_d1 = '0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      en_cnt[i] = 0; nb[i] = 0; nw[i] = 0; bad[i] = 0;
      dcnt[i] = 0; dend[i] = 0; s0[i] = '0; s1[i] = '0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        nb[i] = 0; nw[i] = 0;
      end
      p_sclk = '0; p_en = '0; p_d0 = '0; p_d1 = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (en[i] && !p_en[i]) begin
          en_cnt[i] = 0; nb[i] = 0; nw[i] = 0;
        end
        if (en[i]) en_cnt[i]++;
        if (sclk[i] && !p_sclk[i]) begin
          s0[i] = {s0[i][14:0], d0[i]};
          s1[i] = {s1[i][14:0], d1[i]};
          nb[i]++;
          if (nb[i] % 16 == 0 && nw[i] < 8) begin
            got[i][nw[i]] = {s0[i], s1[i]};
            nw[i]++;
          end
        end
        if ((d0[i] != p_d0[i] || d1[i] != p_d1[i]) &&
            !(p_sclk[i] && !sclk[i]) && !(en[i] && !p_en[i]))
          bad[i]++;
        if (done[i]) dcnt[i]++;
      end
      p_sclk = sclk; p_en = en; p_d0 = d0; p_d1 = d1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [1:0] b, input int k);
    logic [31:0] x;
    x = '0;
    if (k < W) return mem[int'(b) * W + k];
    for (int j = 0; j < W; j++) x ^= mem[int'(b) * W + j];
    return x;
  endfunction

  function automatic logic rd_en_of(input int i);
    return (i == 1) ? mif1.RD_EN : mif0.RD_EN;
  endfunction

  function automatic logic [AW-1:0] rd_addr_of(input int i);
    return (i == 1) ? mif1.RD_ADDR : mif0.RD_ADDR;
  endfunction

  task automatic start(input int i, input logic [1:0] b);
    tick();
    chk("done_once", dcnt[i], dend[i]);
    bn[i] = b;
    trig[i] = 1'b1;
    tick();
    chk("rd_en_t0", 32'(rd_en_of(i)), 1);
    chk("rd_addr_t0", 32'(rd_addr_of(i)), int'(b) * W);
    chk("busy_t0", 32'(busy[i]), 1);
    trig[i] = 1'b0;
    tick();
    chk("en_t1", 32'(en[i]), 0);
    tick();
    chk("en_t2", 32'(en[i]), 1);
    bn[i] = 2'($urandom);
  endtask

  task automatic finish(input int i, input logic [1:0] b);
    int hp;
    int n;
    hp = (i == 1) ? HP1 : HP0;
    n = 0;
    while (dcnt[i] == dend[i] && n < 5000) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(n < 5000), 1);
    dend[i] = dcnt[i];
    chk("en_len", en_cnt[i], NW * 32 * hp);
    chk("nwords", nw[i], NW);
    for (int k = 0; k < NW && k < 8; k++)
      chk("word", got[i][k], exp_word(b, k));
    chk("lane_chg", bad[i], 0);
  endtask

  initial begin
    int n;
    for (int a = 0; a < 16; a++) mem[a] = $urandom;
    for (int a = 8; a < 12; a++) mem[a] = 32'(a);
    mem[4] = 32'hA5A5_5A5A;
    mem[12] = 32'd1; mem[13] = 32'd2; mem[14] = 32'd4; mem[15] = 32'd8;
    bn[0] = '0;
    bn[1] = '0;
    repeat (3) tick();
    chk("rst_out", 32'({en, sclk, d0, d1, busy, done, ovr}), 0);
    rst_n = 1'b1;
    tick();

    start(0, 2); finish(0, 2);
    start(1, 1); finish(1, 1);
    start(0, 3); finish(0, 3);
    repeat (3) begin
      int i;
      logic [1:0] b;
      i = int'($urandom_range(0, 1));
      b = 2'($urandom);
      start(i, b); finish(i, b);
    end

    start(0, 0);
    repeat (20) tick();
    trig[0] = 1'b1;
    tick(); tick();
    chk("ovr_set", 32'(ovr[0]), 1);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    tick();
    chk("ovr_clr", 32'(ovr[0]), 0);
    trig[0] = 1'b0;
    tick();
    trig[0] = 1'b1;
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    tick();
    chk("ovr_set_wins", 32'(ovr[0]), 1);
    finish(0, 0);
    repeat (40) tick();
    chk("held_busy", 32'(busy[0]), 0);
    chk("held_done", dcnt[0], dend[0]);
    trig[0] = 1'b0;
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    tick();
    chk("ovr_clr2", 32'(ovr[0]), 0);

    start(1, 3); finish(1, 3);
    start(1, 2); finish(1, 2);

    start(0, 2);
    n = 0;
    while (nb[0] < 40 && n < 1000) begin
      tick();
      n++;
    end
    chk("bit40_seen", 32'(n < 1000), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 32'({en, sclk, d0, d1, busy, done, ovr,
                        mif0.RD_EN, mif1.RD_EN}), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_no_done", dcnt[0], dend[0]);
    start(0, 2); finish(0, 2);

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/rd_serial_tx.md
Name: rd_serial_tx

Overview:
- Transmit end of the two-lane serial readout link: on trigger, reads one trace buffer from block RAM and streams it out on SERIAL_DATA0_OUT/SERIAL_DATA1_OUT, with a forwarded SERIAL_CLK_OUT and ENABLE_XFR_OUT framing.
- Sits between the trace buffer memory and the board-to-board link that feeds the capture/deserializer side.

Parameters:
- WORDS_PER_BUF, 2048, 32-bit words per buffer (power of 2)
- ADDR_WIDTH, 13, word address width, ≥ log2(WORDS_PER_BUF)+2
- HALF_PERIOD, 1, CLK_IN cycles per SERIAL_CLK_OUT half period (≥1)

Ports:
- CLK_IN  in  1  system clock; all logic on rising edge
- RESETN_IN  in  1  asynchronous active-low reset
- TRIG_IN  in  1  start transfer, sampled level; rising edge detected internally
- BUF_NUM  in  2  buffer to send, latched at accepted trigger
- RD_ADDR  out  ADDR_WIDTH  memory word address = BUF_NUM*WORDS_PER_BUF + index
- RD_EN  out  1  memory read strobe; RD_DATA valid exactly 1 cycle after RD_EN
- RD_DATA  in  32  memory read data
- SERIAL_CLK_OUT  out  1  forwarded bit clock
- SERIAL_DATA0_OUT  out  1  lane 0: word[31:16], MSB first
- SERIAL_DATA1_OUT  out  1  lane 1: word[15:0], MSB first
- ENABLE_XFR_OUT  out  1  high for the whole transfer
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle pulse at end of transfer
- OVERRUN  out  1  sticky: trigger edge arrived while BUSY
- CLR_OVERRUN  in  1  synchronous clear of OVERRUN

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, index 0, trigger edge detector primed to 0.
- States: IDLE, FETCH, LOAD, SHIFT, DONE.
- IDLE: on rising edge of TRIG_IN, latch BUF_NUM, index 0, assert RD_EN with RD_ADDR for word 0 in the same cycle; go to FETCH; BUSY=1.
- FETCH (1 cycle): wait for read latency.
- LOAD: capture RD_DATA into two 16-bit shift registers, set ENABLE_XFR_OUT=1, lane outputs = bit 15 of each half; go to SHIFT. ENABLE_XFR_OUT therefore rises 2 cycles after the trigger edge cycle.
- SHIFT:
  - SERIAL_CLK_OUT starts low and toggles every HALF_PERIOD cycles.
  - Receiver samples on rising edge; data changes only coincident with falling edge (bit period = 2*HALF_PERIOD cycles).
  - After 16 bits, the next word is presented on the same falling edge, with no gap between words.
  - Next-word read issued on the falling edge that launches bit 0 of the current word (prefetch, registered into a holding register).
  - Index increments modulo WORDS_PER_BUF; address never leaves the latched buffer.
- End: after the final falling edge of word WORDS_PER_BUF-1, bit 0 holds for one full period; at its closing falling edge ENABLE_XFR_OUT, SERIAL_CLK_OUT and both data lanes go 0; go to DONE.
- DONE: DONE=1 for one cycle, BUSY=0 next cycle, return to IDLE.
- Total ENABLE_XFR_OUT high time: WORDS_PER_BUF*16*2*HALF_PERIOD cycles.
- Trigger edge while BUSY is ignored and sets OVERRUN.
- Trigger edge in the same cycle as CLR_OVERRUN while BUSY leaves OVERRUN set (set wins).
- TRIG_IN held high does not retrigger; a new rising edge is required.
- BUF_NUM changes during a transfer have no effect.
- Reset mid-transfer: outputs drop immediately to 0 and no DONE pulse is issued.

Optional Feature:
- Macro: RD_SERIAL_TX_CHECKSUM_EN.
- When defined:
  - After the last data word, one extra 32-bit word equal to the XOR of all transmitted words is sent in the same format.
  - ENABLE_XFR_OUT stays high for it, so high time = (WORDS_PER_BUF+1)*32*HALF_PERIOD cycles.
  - Checksum accumulator clears at trigger acceptance.
- When undefined: no checksum word and no accumulator logic.

Test Plan:
- WORDS_PER_BUF=4, HALF_PERIOD=1, BUF_NUM=2, memory word = address:
  - Trigger edge at cycle T → RD_ADDR=8 with RD_EN at T.
  - ENABLE_XFR_OUT rises at T+2 and stays high 128 cycles.
  - Lanes deliver 0x0000/0x0008, 0x0000/0x0009, 0x0000/0x000A, 0x0000/0x000B sampled on SERIAL_CLK_OUT rising edges.
  - DONE pulses once.
- HALF_PERIOD=3, word 0xA5A5_5A5A → lane0 bits 1,0,1,0,0,1,0,1,… and lane1 0,1,0,1,1,0,1,0,…, each bit stable 6 cycles, changing only on falling edges.
- Second TRIG_IN edge mid-transfer → transfer unaffected, OVERRUN=1 until CLR_OVERRUN pulse; TRIG_IN held high after DONE → no new transfer.
- RESETN_IN low at bit 40 → all outputs 0 within the same cycle, no DONE; fresh trigger afterwards restarts from index 0.
- Back-to-back: trigger edge in the cycle after DONE → new transfer starts normally with a correct first word.
- With RD_SERIAL_TX_CHECKSUM_EN, words 1,2,4,8 → fifth word 0x0000000F, ENABLE high 160 cycles at HALF_PERIOD=1.
